mem_access_unit: RTL and testbench

- Memory-stage front end that sits directly upstream of the data memory, between the EX/MEM pipeline register and the word-wide synchronous dmem.
- Turns RV32I byte, halfword and word loads/stores into word accesses.
- The dmem only writes full words, so SB/SH are done as a read-modify-write that costs one stall cycle.
- Also aligns and sign- or zero-extends load data, which returns one cycle later, for writeback.

---
 rtl/mem_access_unit_pkg.sv | 33 +++
 rtl/mem_access_unit_lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access unit: RV32I funct3 codes,
// FSM state encoding and the load tracker record.
package MemOps;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] funct3;
    logic [1:0] offset;
  } ld_trk_t;

  // Low offset bits that cannot address a lane of the access width are masked.
  function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] r;
    case (f3)
      F3_B, F3_BU: r = off;
      F3_H, F3_HU: r = {off[1], 1'b0};
      default:     r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane logic: store merge into an old word and load
// extraction with sign/zero extension.
module mem_lane_align
  import MemOps::*;
(
  input  logic [31:0] st_old_i,
  input  logic [31:0] st_new_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_offset_i,
  output logic [31:0] st_word_o,
  input  logic [31:0] ld_word_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_offset_i,
  output logic [31:0] ld_result_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_word_o = st_old_i;
    case (st_funct3_i)
      F3_B:    st_word_o[{st_offset_i, 3'b000} +: 8]     = st_new_i[7:0];
      F3_H:    st_word_o[{st_offset_i[1], 4'b0000} +: 16] = st_new_i[15:0];
      default: st_word_o = st_old_i;
    endcase
  end

  always_comb begin
    ld_byte = ld_word_i[{ld_offset_i, 3'b000} +: 8];
    ld_half = ld_word_i[{ld_offset_i[1], 4'b0000} +: 16];
    case (ld_funct3_i)
      F3_B:    ld_result_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_result_o = {24'h000000, ld_byte};
      F3_H:    ld_result_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_result_o = {16'h0000, ld_half};
      F3_W:    ld_result_o = ld_word_i;
      default: ld_result_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage front end: word-wide dmem access, read-modify-write for SB/SH,
// load alignment. Optional trap on misaligned/illegal access via MISALIGN_TRAP_EN.
module mem_access_unit
  import MemOps::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_stall,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_load_valid,
  output logic                  o_misaligned
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [31:0]           wdata_q, wdata_d;
  ld_trk_t               trk_q, trk_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            off;
  logic                  unused_addr;
  logic                  want_st, want_ld;
  logic                  f3_st_ok, f3_ld_ok;
  logic                  trap;
  logic                  do_ld, do_sw, do_sub;
  logic                  we_c, stall_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [31:0]           wdata_c;
  logic [31:0]           merged, ld_res;

  assign word_idx    = i_addr[ADDR_WIDTH+1:2];
  assign off         = i_addr[1:0];
  assign unused_addr = ^i_addr[31:ADDR_WIDTH+2];

  assign want_st  = i_valid & i_mem_write;
  assign want_ld  = i_valid & i_mem_read & ~i_mem_write;
  assign f3_st_ok = (i_funct3 == F3_B) | (i_funct3 == F3_H) | (i_funct3 == F3_W);
  assign f3_ld_ok = f3_st_ok | (i_funct3 == F3_BU) | (i_funct3 == F3_HU);

`ifdef MISALIGN_TRAP_EN
  logic align_bad;
  assign align_bad = (((i_funct3 == F3_H) | (i_funct3 == F3_HU)) & off[0])
                   | ((i_funct3 == F3_W) & (off != 2'b00));
  assign trap = (want_st & (~f3_st_ok | align_bad)) | (want_ld & (~f3_ld_ok | align_bad));
`else
  assign trap = 1'b0;
`endif

  assign do_ld  = (state_q == IDLE) & want_ld & f3_ld_ok & ~trap;
  assign do_sw  = (state_q == IDLE) & want_st & (i_funct3 == F3_W) & ~trap;
  assign do_sub = (state_q == IDLE) & want_st & ((i_funct3 == F3_B) | (i_funct3 == F3_H)) & ~trap;

  mem_lane_align u_lane (
    .st_old_i    (i_dmem_rdata),
    .st_new_i    (wdata_q),
    .st_funct3_i (f3_q),
    .st_offset_i (off_q),
    .st_word_o   (merged),
    .ld_word_i   (i_dmem_rdata),
    .ld_funct3_i (trk_q.funct3),
    .ld_offset_i (trk_q.offset),
    .ld_result_o (ld_res)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    trk_d   = '0;
    we_c    = 1'b0;
    stall_c = 1'b0;
    addr_c  = word_idx;
    wdata_c = i_wdata;
    case (state_q)
      IDLE: begin
        trk_d.valid  = do_ld;
        trk_d.funct3 = i_funct3;
        trk_d.offset = eff_offset(i_funct3, off);
        we_c         = do_sw;
        if (do_sub) begin
          stall_c = 1'b1;
          addr_d  = word_idx;
          off_d   = eff_offset(i_funct3, off);
          f3_d    = i_funct3;
          wdata_d = i_wdata;
          state_d = MERGE;
        end
      end
      MERGE: begin
        we_c    = 1'b1;
        addr_c  = addr_q;
        wdata_c = merged;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      trk_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      trk_q   <= trk_d;
    end
  end

  // Strobes are gated by reset so an in-flight merge write is dropped at once.
  assign o_dmem_we    = we_c & ~i_rst;
  assign o_stall      = stall_c & ~i_rst;
  assign o_misaligned = trap & ~i_rst;
  assign o_dmem_addr  = addr_c;
  assign o_dmem_wdata = wdata_c;
  assign o_load_valid = trk_q.valid;
  assign o_load_data  = trk_q.valid ? ld_res : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural synchronous dmem.
module tb_mem_access_unit;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, rd, wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        stall, we, load_valid, mis;
  logic [8:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata, load_data;
  logic [31:0] ram [0:511];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) ram[dmem_addr] <= dmem_wdata;
    dmem_rdata <= ram[dmem_addr];
  end

  mem_access_unit #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_mem_read   (rd),
    .i_mem_write  (wr),
    .i_funct3     (f3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_stall      (stall),
    .o_dmem_we    (we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_rdata (dmem_rdata),
    .o_load_data  (load_data),
    .o_load_valid (load_valid),
    .o_misaligned (mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    valid = v; rd = r; wr = w; f3 = f; addr = a; wdata = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, W, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b1; rd = 1'b0; wr = 1'b1; f3 = B; addr = 32'h11; wdata = 32'hAB;
    #7;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_lvalid", {31'b0, load_valid}, 32'd0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_mis", {31'b0, mis}, 32'd0);
    @(negedge clk);
    valid = 1'b0; wr = 1'b0;
    rst = 1'b0;

    // preload through single-cycle SW
    drive(1, 0, 1, W, 32'h10, 32'h11223344);
    chk("sw_we", {31'b0, we}, 32'd1);
    chk("sw_addr", {23'b0, dmem_addr}, 32'd4);
    chk("sw_stall", {31'b0, stall}, 32'd0);
    drive(1, 0, 1, W, 32'h08, 32'h80FF7F01);
    drive(1, 0, 1, W, 32'h0C, 32'hAAAAAAAA);
    drive(1, 0, 1, W, 32'h00, 32'h12345678);

    drive(1, 1, 0, W, 32'h10, 32'h0);
    chk("lw_addr", {23'b0, dmem_addr}, 32'd4);
    chk("lw_we", {31'b0, we}, 32'd0);
    chk("lw_stall", {31'b0, stall}, 32'd0);
    idle();
    chk("lw_valid", {31'b0, load_valid}, 32'd1);
    chk("lw_data", load_data, 32'h11223344);
    idle();
    chk("idle_lvalid", {31'b0, load_valid}, 32'd0);
    chk("idle_ldata", load_data, 32'h0);

    drive(1, 0, 1, B, 32'h11, 32'h000000AB);
    chk("sb_c0_stall", {31'b0, stall}, 32'd1);
    chk("sb_c0_we", {31'b0, we}, 32'd0);
    chk("sb_c0_addr", {23'b0, dmem_addr}, 32'd4);
    tick();
    chk("sb_c1_we", {31'b0, we}, 32'd1);
    chk("sb_c1_wdata", dmem_wdata, 32'h1122AB44);
    chk("sb_c1_stall", {31'b0, stall}, 32'd0);
    chk("sb_c1_addr", {23'b0, dmem_addr}, 32'd4);
    drive(1, 1, 0, W, 32'h10, 32'h0);
    chk("lw_after_sb_stall", {31'b0, stall}, 32'd0);
    idle();
    chk("lw_after_sb", load_data, 32'h1122AB44);

    drive(1, 1, 0, B, 32'h0A, 32'h0); idle();
    chk("lb_0a", load_data, 32'hFFFFFFFF);
    drive(1, 1, 0, BU, 32'h0B, 32'h0); idle();
    chk("lbu_0b", load_data, 32'h00000080);
    drive(1, 1, 0, H, 32'h08, 32'h0); idle();
    chk("lh_08", load_data, 32'h00007F01);
    drive(1, 1, 0, HU, 32'h0A, 32'h0); idle();
    chk("lhu_0a", load_data, 32'h000080FF);

    drive(1, 0, 1, H, 32'h0E, 32'h0000BEEF);
    chk("sh_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("sh_c1_we", {31'b0, we}, 32'd1);
    chk("sh_c1_wdata", dmem_wdata, 32'hBEEFAAAA);
    chk("sh_c1_addr", {23'b0, dmem_addr}, 32'd3);
    drive(1, 1, 0, H, 32'h0E, 32'h0); idle();
    chk("lh_after_sh", load_data, 32'hFFFFBEEF);

    drive(1, 0, 1, B, 32'h00, 32'h00000055);
    chk("rsb_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("rsb_merge_we", {31'b0, we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rsb_rst_we", {31'b0, we}, 32'd0);
    chk("rsb_rst_stall", {31'b0, stall}, 32'd0);
    #1 rst = 1'b0;
    valid = 1'b0; wr = 1'b0;
    drive(1, 1, 0, W, 32'h00, 32'h0);
    chk("rsb_idle_stall", {31'b0, stall}, 32'd0);
    chk("rsb_idle_we", {31'b0, we}, 32'd0);
    idle();
    chk("rsb_no_write", load_data, 32'h12345678);

    drive(1, 1, 1, W, 32'h18, 32'h0000BEEF);
    chk("rw_we", {31'b0, we}, 32'd1);
    chk("rw_addr", {23'b0, dmem_addr}, 32'd6);
    idle();
    chk("rw_no_lvalid", {31'b0, load_valid}, 32'd0);
    drive(1, 1, 0, W, 32'h18, 32'h0); idle();
    chk("rw_readback", load_data, 32'h0000BEEF);

    drive(0, 0, 1, W, 32'h1C, 32'hFFFFFFFF);
    chk("novalid_we", {31'b0, we}, 32'd0);
    chk("novalid_stall", {31'b0, stall}, 32'd0);

    drive(1, 1, 0, 3'b011, 32'h10, 32'h0);
    chk("f3_011_stall", {31'b0, stall}, 32'd0);
    idle();
    chk("f3_011_lvalid", {31'b0, load_valid}, 32'd0);
    drive(1, 0, 1, 3'b110, 32'h10, 32'h0);
    chk("f3_110_we", {31'b0, we}, 32'd0);

    drive(1, 1, 0, W, 32'h810, 32'h0);
    chk("wrap_addr", {23'b0, dmem_addr}, 32'd4);
    idle();
    chk("wrap_data", load_data, 32'h1122AB44);

    drive(1, 1, 0, W, 32'h13, 32'h0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", {31'b0, mis}, 32'd1);
    idle();
    chk("mis_lvalid", {31'b0, load_valid}, 32'd0);
`else
    chk("mis_flag", {31'b0, mis}, 32'd0);
    chk("mis_addr", {23'b0, dmem_addr}, 32'd4);
    idle();
    chk("mis_lvalid", {31'b0, load_valid}, 32'd1);
    chk("mis_data", load_data, 32'h1122AB44);
`endif

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
